// File: rtl/lighthouse_sensor_array.sv
`default_nettype none
// ============================================================================
// Module   : lighthouse_sensor_array
// Purpose  : N-channel collector for lighthouse sensor words. Each sensor's
//            word is captured on its strobe into a holding register, pending
//            words are granted round-robin into a tagged first-word-fall-
//            through FIFO, and the FIFO drains over a valid/ready stream.
// Options  : define LH_SENSOR_STALE_EN to build the per-sensor staleness
//            monitor (millisecond prescaler plus one counter per sensor).
//            Without it stale_o is tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module lighthouse_sensor_array #(
   parameter int NUMBER_OF_SENSORS = 20,
   parameter int DATA_WIDTH        = 32,
   parameter int FIFO_DEPTH        = 16,
   parameter int CLK_SPEED         = 50_000_000,
   parameter int STALE_MS          = 100
) (
   input  logic                                      clock,
   input  logic                                      reset_n,
   input  logic [NUMBER_OF_SENSORS*DATA_WIDTH-1:0]   sensor_data_i,
   input  logic [NUMBER_OF_SENSORS-1:0]              sensor_strobe_i,
   output logic                                      out_valid_o,
   input  logic                                      out_ready_i,
   output logic [DATA_WIDTH-1:0]                     out_data_o,
   output logic [9:0]                                out_id_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]           fifo_level_o,
   output logic [15:0]                               overwrite_count_o,
   output logic [NUMBER_OF_SENSORS-1:0]              pending_o,
   output logic [NUMBER_OF_SENSORS-1:0]              stale_o
);

   localparam int N       = NUMBER_OF_SENSORS;
   localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
   localparam int HIT_W   = $clog2(N + 1);
   localparam int ENTRY_W = 10 + DATA_WIDTH;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] holding_q [N];
   logic [DATA_WIDTH-1:0] holding_d [N];
   logic [N-1:0]          pending_q, pending_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [15:0]           overwrite_q, overwrite_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [ENTRY_W-1:0]    fifo_mem_q [FIFO_DEPTH];

   // ------------------------------------------------------------------------
   // Arbiter / handshake wires
   // ------------------------------------------------------------------------
   logic [N-1:0]          upper_mask;
   logic [N-1:0]          pend_upper;
   logic [IDX_W-1:0]      grant_idx;
   logic [N-1:0]          grant_onehot;
   logic                  fifo_full;
   logic                  grant;
   logic                  pop;
   logic [ENTRY_W-1:0]    push_entry;
   logic [ENTRY_W-1:0]    head_entry;
   logic [HIT_W-1:0]      overwrite_hits;
   logic [31:0]           overwrite_sum;

   // Round-robin pick: lowest pending index at/above rr_ptr, else lowest overall
   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < N; i++) begin
         upper_mask[i] = (IDX_W'(i) >= rr_ptr_q);
      end
      pend_upper = pending_q & upper_mask;
      grant_idx  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) grant_idx = IDX_W'(i);
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (pend_upper[i]) grant_idx = IDX_W'(i);
      end
      fifo_full    = (level_q == LVL_W'(FIFO_DEPTH));
      // A pop in a full cycle does not free a slot for the same cycle's push
      grant        = (|pending_q) && !fifo_full;
      grant_onehot = grant ? (N'(1) << grant_idx) : '0;
      pop          = out_valid_o && out_ready_i;
      push_entry   = {10'(grant_idx), holding_q[grant_idx]};
      rr_ptr_d     = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

   // Capture strobed words; a strobe on the granted sensor keeps it pending
   always_comb begin
      pending_d      = pending_q;
      overwrite_hits = '0;
      for (int i = 0; i < N; i++) begin
         holding_d[i] = holding_q[i];
         if (sensor_strobe_i[i]) begin
            holding_d[i] = sensor_data_i[DATA_WIDTH*i +: DATA_WIDTH];
            pending_d[i] = 1'b1;
            // The old word is lost only if it was not pushed this cycle
            if (pending_q[i] && !grant_onehot[i]) begin
               overwrite_hits = overwrite_hits + HIT_W'(1);
            end
         end else if (grant_onehot[i]) begin
            pending_d[i] = 1'b0;
         end
      end
      overwrite_sum = 32'(overwrite_q) + 32'(overwrite_hits);
      overwrite_d   = (overwrite_sum > 32'h0000_FFFF) ? 16'hFFFF : overwrite_sum[15:0];
   end

   // FIFO pointer and occupancy bookkeeping
   always_comb begin
      wr_ptr_d = grant ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({grant, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Control and holding registers, cleared immediately on reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending_q   <= '0;
         rr_ptr_q    <= '0;
         overwrite_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         for (int i = 0; i < N; i++) begin
            holding_q[i] <= '0;
         end
      end else begin
         pending_q   <= pending_d;
         rr_ptr_q    <= rr_ptr_d;
         overwrite_q <= overwrite_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         for (int i = 0; i < N; i++) begin
            holding_q[i] <= holding_d[i];
         end
      end
   end

   // FIFO storage; contents are invalidated by the level reset, not cleared
   always_ff @(posedge clock) begin
      if (grant) begin
         fifo_mem_q[wr_ptr_q] <= push_entry;
      end
   end

   // Head outputs are forced to zero whenever the FIFO is empty
   always_comb begin
      head_entry        = fifo_mem_q[rd_ptr_q];
      out_valid_o       = (level_q != '0);
      out_data_o        = out_valid_o ? head_entry[DATA_WIDTH-1:0] : '0;
      out_id_o          = out_valid_o ? head_entry[ENTRY_W-1:DATA_WIDTH] : '0;
      fifo_level_o      = level_q;
      overwrite_count_o = overwrite_q;
      pending_o         = pending_q;
   end

`ifdef LH_SENSOR_STALE_EN
   localparam int TICK_CYCLES = (CLK_SPEED / 1000 > 0) ? CLK_SPEED / 1000 : 1;
   localparam int PRE_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int MS_W        = (STALE_MS > 0) ? $clog2(STALE_MS + 1) : 1;

   logic [PRE_W-1:0] presc_q, presc_d;
   logic             ms_tick;
   logic [MS_W-1:0]  ms_cnt_q [N];
   logic [MS_W-1:0]  ms_cnt_d [N];
   logic [N-1:0]     seen_q, seen_d;

   // Shared millisecond prescaler and per-sensor saturating age counters
   always_comb begin
      ms_tick = (presc_q == PRE_W'(TICK_CYCLES - 1));
      presc_d = ms_tick ? '0 : presc_q + PRE_W'(1);
      seen_d  = seen_q | sensor_strobe_i;
      for (int i = 0; i < N; i++) begin
         ms_cnt_d[i] = ms_cnt_q[i];
         if (sensor_strobe_i[i]) begin
            ms_cnt_d[i] = '0;
         end else if (ms_tick && (ms_cnt_q[i] != MS_W'(STALE_MS))) begin
            ms_cnt_d[i] = ms_cnt_q[i] + MS_W'(1);
         end
      end
   end

   // Age registers; a sensor is stale until its first strobe after reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         seen_q  <= '0;
         for (int i = 0; i < N; i++) begin
            ms_cnt_q[i] <= '0;
         end
      end else begin
         presc_q <= presc_d;
         seen_q  <= seen_d;
         for (int i = 0; i < N; i++) begin
            ms_cnt_q[i] <= ms_cnt_d[i];
         end
      end
   end

   // Stale when never strobed or the age counter has saturated
   always_comb begin
      for (int i = 0; i < N; i++) begin
         stale_o[i] = !seen_q[i] || (ms_cnt_q[i] == MS_W'(STALE_MS));
      end
   end
`else
   // Timing parameters only matter to the staleness monitor
   logic unused_stale_cfg;
   assign unused_stale_cfg = ^{32'(CLK_SPEED), 32'(STALE_MS)};
   assign stale_o          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lighthouse_sensor_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_lighthouse_sensor_array
// Purpose  : self-checking bench for lighthouse_sensor_array: directed vector
//            table, hand-written corner sequences and random traffic compared
//            against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lighthouse_sensor_array;

   localparam int N     = 20;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [N*DW-1:0]  sensor_data_i;
   logic [N-1:0]     sensor_strobe_i = '0;
   logic             out_ready_i = 1'b0;
   logic             out_valid_o;
   logic [DW-1:0]    out_data_o;
   logic [9:0]       out_id_o;
   logic [LVL_W-1:0] fifo_level_o;
   logic [15:0]      overwrite_count_o;
   logic [N-1:0]     pending_o;
   logic [N-1:0]     stale_o;

   logic [DW-1:0]    words [N];

   lighthouse_sensor_array #(
      .NUMBER_OF_SENSORS (N),
      .DATA_WIDTH        (DW),
      .FIFO_DEPTH        (DEPTH),
      .CLK_SPEED         (10_000),
      .STALE_MS          (3)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .sensor_data_i     (sensor_data_i),
      .sensor_strobe_i   (sensor_strobe_i),
      .out_valid_o       (out_valid_o),
      .out_ready_i       (out_ready_i),
      .out_data_o        (out_data_o),
      .out_id_o          (out_id_o),
      .fifo_level_o      (fifo_level_o),
      .overwrite_count_o (overwrite_count_o),
      .pending_o         (pending_o),
      .stale_o           (stale_o)
   );

   always #5 clock = ~clock;

   always_comb begin
      for (int i = 0; i < N; i++) sensor_data_i[i*DW +: DW] = words[i];
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [9:0]    id;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        mq[$];
   entry_t        got[$];
   logic [DW-1:0] m_hold [N];
   logic [N-1:0]  m_pend;
   int            m_rr;
   int            m_ow;

   function automatic void model_reset();
      mq.delete();
      m_pend = '0;
      m_rr   = 0;
      m_ow   = 0;
      for (int i = 0; i < N; i++) m_hold[i] = '0;
   endfunction

   function automatic void model_step();
      int     gi     = -1;
      bit     do_pop = (mq.size() != 0) && out_ready_i;
      entry_t e;
      if (mq.size() < DEPTH) begin
         for (int k = 0; k < N; k++) begin
            if (gi < 0 && m_pend[(m_rr + k) % N]) gi = (m_rr + k) % N;
         end
      end
      if (do_pop) void'(mq.pop_front());
      if (gi >= 0) begin
         e.id   = 10'(gi);
         e.data = m_hold[gi];
         mq.push_back(e);
         m_pend[gi] = 1'b0;
         m_rr       = (gi + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         if (sensor_strobe_i[i]) begin
            if (m_pend[i] && m_ow < 65535) m_ow++;
            m_hold[i] = words[i];
            m_pend[i] = 1'b1;
         end
      end
   endfunction

   task automatic check_model();
      check("m_valid", 64'(out_valid_o), 64'(mq.size() != 0));
      check("m_level", 64'(fifo_level_o), 64'(mq.size()));
      check("m_pending", 64'(pending_o), 64'(m_pend));
      check("m_overwrite", 64'(overwrite_count_o), 64'(m_ow));
      if (mq.size() != 0) begin
         check("m_head_id", 64'(out_id_o), 64'(mq[0].id));
         check("m_head_data", 64'(out_data_o), 64'(mq[0].data));
      end
`ifndef LH_SENSOR_STALE_EN
      check("m_stale_off", 64'(stale_o), 64'd0);
`endif
   endtask

   // One clock: model advances with the DUT, outputs sampled 1 time unit later
   task automatic tick();
      @(posedge clock);
      if (reset_n) model_step();
      else         model_reset();
      #1;
      check_model();
   endtask

   task automatic pulse(input logic [N-1:0] mask);
      sensor_strobe_i = mask;
      tick();
      sensor_strobe_i = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      model_reset();
      check("rst_level", 64'(fifo_level_o), 64'd0);
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_pending", 64'(pending_o), 64'd0);
      check("rst_overwrite", 64'(overwrite_count_o), 64'd0);
      check("rst_data", 64'(out_data_o), 64'd0);
      check("rst_id", 64'(out_id_o), 64'd0);
`ifdef LH_SENSOR_STALE_EN
      check("rst_stale", 64'(stale_o), 64'(20'hFFFFF));
`else
      check("rst_stale", 64'(stale_o), 64'd0);
`endif
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic drain(input int budget);
      entry_t e;
      got.delete();
      out_ready_i = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (out_valid_o) begin
            e.id   = out_id_o;
            e.data = out_data_o;
            got.push_back(e);
         end
         tick();
         if (!out_valid_o && pending_o == '0) break;
      end
      out_ready_i = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [N-1:0]     strobe;
      logic [DW-1:0]    base;
      logic             ready;
      logic             exp_valid;
      logic [9:0]       exp_id;
      logic [DW-1:0]    exp_data;
      logic [LVL_W-1:0] exp_level;
      logic [N-1:0]     exp_pend;
   } vec_t;

   vec_t vecs[11];
   int   n;
   bit   found;
   bit   ok;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // strobe, base(word=base+i), ready, valid, id, data, level, pending
      vecs[0]  = '{20'h00020, 32'hDEADBEEA, 1'b1, 1'b0, 10'd0,  32'h0,        5'd0, 20'h00020};
      vecs[1]  = '{20'h00000, 32'h0,        1'b1, 1'b1, 10'd5,  32'hDEADBEEF, 5'd1, 20'h00000};
      vecs[2]  = '{20'h00000, 32'h0,        1'b1, 1'b0, 10'd0,  32'h0,        5'd0, 20'h00000};
      vecs[3]  = '{20'h00080, 32'h70,       1'b1, 1'b0, 10'd0,  32'h0,        5'd0, 20'h00080};
      vecs[4]  = '{20'h00000, 32'h0,        1'b1, 1'b1, 10'd7,  32'h77,       5'd1, 20'h00000};
      vecs[5]  = '{20'h00000, 32'h0,        1'b1, 1'b0, 10'd0,  32'h0,        5'd0, 20'h00000};
      vecs[6]  = '{20'h01088, 32'h1000,     1'b1, 1'b0, 10'd0,  32'h0,        5'd0, 20'h01088};
      vecs[7]  = '{20'h00000, 32'h0,        1'b1, 1'b1, 10'd12, 32'h100C,     5'd1, 20'h00088};
      vecs[8]  = '{20'h00000, 32'h0,        1'b1, 1'b1, 10'd3,  32'h1003,     5'd1, 20'h00080};
      vecs[9]  = '{20'h00000, 32'h0,        1'b1, 1'b1, 10'd7,  32'h1007,     5'd1, 20'h00000};
      vecs[10] = '{20'h00000, 32'h0,        1'b1, 1'b0, 10'd0,  32'h0,        5'd0, 20'h00000};

      for (int i = 0; i < N; i++) words[i] = '0;
      model_reset();
      do_reset();

      // Single sample and round-robin order 12, 3, 7 from rr_ptr=8
      for (int v = 0; v < 11; v++) begin
         for (int i = 0; i < N; i++) words[i] = vecs[v].base + DW'(i);
         out_ready_i = vecs[v].ready;
         pulse(vecs[v].strobe);
         check($sformatf("vec%0d_valid", v), 64'(out_valid_o), 64'(vecs[v].exp_valid));
         check($sformatf("vec%0d_level", v), 64'(fifo_level_o), 64'(vecs[v].exp_level));
         check($sformatf("vec%0d_pending", v), 64'(pending_o), 64'(vecs[v].exp_pend));
         if (vecs[v].exp_valid) begin
            check($sformatf("vec%0d_id", v), 64'(out_id_o), 64'(vecs[v].exp_id));
            check($sformatf("vec%0d_data", v), 64'(out_data_o), 64'(vecs[v].exp_data));
         end
      end
      out_ready_i = 1'b0;

      // Overwrite while the FIFO is full
      do_reset();
      for (int i = 0; i < N; i++) words[i] = 32'h2000 + DW'(i);
      pulse(20'hFFFF0);
      repeat (16) tick();
      check("ow_fill_level", 64'(fifo_level_o), 64'd16);
      words[2] = 32'h1;
      pulse(20'h00004);
      words[2] = 32'h2;
      pulse(20'h00004);
      check("ow_count", 64'(overwrite_count_o), 64'd1);
      check("ow_pending2", 64'(pending_o[2]), 64'd1);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      tick();
      drain(40);
      check("ow_drain_count", 64'(got.size()), 64'd16);
      found = 1'b0;
      ok    = 1'b1;
      foreach (got[k]) begin
         if (got[k].id == 10'd2) begin
            found = 1'b1;
            if (got[k].data != 32'h2) ok = 1'b0;
         end
      end
      check("ow_sensor2_word", 64'({found, ok}), 64'(2'b11));

      // Full back-pressure with all 20 sensors
      do_reset();
      for (int i = 0; i < N; i++) words[i] = 32'h3000 + DW'(i);
      pulse(20'hFFFFF);
      repeat (24) tick();
      check("bp_level", 64'(fifo_level_o), 64'd16);
      check("bp_pending_cnt", 64'($countones(pending_o)), 64'd4);
      check("bp_pending", 64'(pending_o), 64'(20'hF0000));
      drain(60);
      check("bp_drain_count", 64'(got.size()), 64'd20);
      for (int k = 0; k < 20; k++) begin
         if (k < got.size()) begin
            check($sformatf("bp_id%0d", k), 64'(got[k].id), 64'(k));
            check($sformatf("bp_data%0d", k), 64'(got[k].data), 64'(32'h3000 + k));
         end
      end

      // Grant and strobe on the same sensor in the same cycle
      do_reset();
      words[0] = 32'hA;
      pulse(20'h00001);
      words[0] = 32'hB;
      pulse(20'h00001);
      check("sc_level", 64'(fifo_level_o), 64'd1);
      check("sc_head", 64'(out_data_o), 64'hA);
      check("sc_id", 64'(out_id_o), 64'd0);
      check("sc_pending0", 64'(pending_o[0]), 64'd1);
      check("sc_overwrite", 64'(overwrite_count_o), 64'd0);
      tick();
      check("sc_level2", 64'(fifo_level_o), 64'd2);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      check("sc_second", 64'(out_data_o), 64'hB);

      // Random traffic: slow consumer first, then a fast one
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            sensor_strobe_i[i] = ($urandom_range(7) == 0);
            words[i]           = $urandom;
         end
         if (c < 200) out_ready_i = ($urandom_range(3) == 0);
         else         out_ready_i = ($urandom_range(3) != 0);
         tick();
      end
      sensor_strobe_i = '0;
      out_ready_i     = 1'b0;

      // Reset with traffic still queued
      do_reset();

`ifdef LH_SENSOR_STALE_EN
      check("stale4_after_reset", 64'(stale_o[4]), 64'd1);
      pulse(20'h00010);
      check("stale4_cleared", 64'(stale_o[4]), 64'd0);
      found = 1'b0;
      n     = 0;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (!found && stale_o[4]) begin
            found = 1'b1;
            n     = c;
         end
      end
      check("stale4_reassert_window", 64'(found && n >= 20 && n <= 41), 64'd1);
`else
      for (int c = 0; c < 60; c++) begin
         if (c % 7 == 0) pulse(20'h00010);
         else            tick();
      end
      check("stale_disabled", 64'(stale_o), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
